// File: rtl/sec_serial_decode_ctrl.sv
// Sequential SEC decoder controller for the AN code (A=655, 14-bit codewords).
// Reduces the codeword bit-serially to r = c mod A, then walks the error
// locations +/-1..+/-N by regenerating 2^(l-1) mod A, one per cycle.
// Optional macro SEC_STATS_EN adds clr_cnt and saturating cnt_ce/cnt_ue.
module sec_serial_decode_ctrl #(
  parameter int A  = 655,
  parameter int N  = 14,
  parameter int RW = 10,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [LW-1:0] out_loc,
  output logic          out_ce,
  output logic          out_ue,
`ifdef SEC_STATS_EN
  input  logic          clr_cnt,
  output logic [15:0]   cnt_ce,
  output logic [15:0]   cnt_ue,
`endif
  output logic [RW-1:0] out_rem
);

  localparam int KW = $clog2(N);
  localparam int IW = $clog2(N + 1);
  localparam logic [RW:0]   A_W = (RW+1)'(A);
  localparam logic [RW-1:0] A_R = RW'(A);

  typedef enum logic [2:0] {IDLE, REDUCE, CHECK, SEARCH, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    cw;
  logic [RW-1:0]   r;
  logic [KW-1:0]   k;
  logic [RW-1:0]   w;
  logic [IW-1:0]   idx;

  // Datapath helpers: one reduction step, one weight doubling, compares.
  logic [RW:0]     t_red;
  logic [RW-1:0]   r_step;
  logic [RW:0]     w_dbl;
  logic [RW-1:0]   w_step;
  logic [N-1:0]    pow;
  logic [LW-1:0]   loc_mag;
  logic            pos_hit, neg_hit, last_idx;

  assign t_red    = {r, cw[k]};
  assign r_step   = (t_red >= A_W) ? RW'(t_red - A_W) : RW'(t_red);
  assign w_dbl    = {w, 1'b0};
  assign w_step   = (w_dbl >= A_W) ? RW'(w_dbl - A_W) : RW'(w_dbl);
  assign pow      = {{(N-1){1'b0}}, 1'b1} << (idx - IW'(1));
  assign loc_mag  = LW'(idx);
  assign pos_hit  = (r == w);
  assign neg_hit  = (r == (A_R - w));
  assign last_idx = (idx == IW'(N));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = REDUCE;
      REDUCE:  if (k == '0) state_nxt = CHECK;
      CHECK:   state_nxt = (r == '0) ? DONE : SEARCH;
      SEARCH:  if (pos_hit || neg_hit || last_idx) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers and result registers; results only change on DONE entry.
  // NOTE: every register here is a plain flop (no memory array), so all of
  // them sit on the async reset and a mid-operation reset leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw       <= '0;
      r        <= '0;
      k        <= '0;
      w        <= '0;
      idx      <= '0;
      out_data <= '0;
      out_loc  <= '0;
      out_ce   <= 1'b0;
      out_ue   <= 1'b0;
      out_rem  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cw <= in_data;
          r  <= '0;
          k  <= KW'(N - 1);
        end
        REDUCE: begin
          r <= r_step;
          k <= k - KW'(1);
        end
        CHECK: if (r == '0) begin
          out_data <= cw;
          out_loc  <= '0;
          out_ce   <= 1'b0;
          out_ue   <= 1'b0;
          out_rem  <= r;
        end else begin
          w   <= RW'(1);
          idx <= IW'(1);
        end
        SEARCH: begin
          // Positive match wins; with A odd both cannot hit at once anyway.
          if (pos_hit) begin
            out_data <= cw - pow;
            out_loc  <= loc_mag;
            out_ce   <= 1'b1;
            out_ue   <= 1'b0;
            out_rem  <= r;
          end else if (neg_hit) begin
            out_data <= cw + pow;
            out_loc  <= -loc_mag;
            out_ce   <= 1'b1;
            out_ue   <= 1'b0;
            out_rem  <= r;
          end else if (last_idx) begin
            out_data <= cw;
            out_loc  <= '0;
            out_ce   <= 1'b0;
            out_ue   <= 1'b1;
            out_rem  <= r;
          end else begin
            w   <= w_step;
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEC_STATS_EN
  // Saturating event counters, bumped on the result handshake; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ce <= '0;
      cnt_ue <= '0;
    end else if (clr_cnt) begin
      cnt_ce <= '0;
      cnt_ue <= '0;
    end else if (out_valid && out_ready) begin
      if (out_ce && (cnt_ce != '1)) cnt_ce <= cnt_ce + 16'd1;
      if (out_ue && (cnt_ue != '1)) cnt_ue <= cnt_ue + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sec_serial_decode_ctrl.sv
// Self-checking bench for sec_serial_decode_ctrl: directed vector table plus
// hand-written sequences for output stall, reset abort and (optional) stats.
module tb_sec_serial_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_data;
  logic [4:0]  out_loc;
  logic        out_ce, out_ue;
  logic [9:0]  out_rem;
`ifdef SEC_STATS_EN
  logic        clr_cnt = 1'b0;
  logic [15:0] cnt_ce, cnt_ue;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sec_serial_decode_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_loc   (out_loc),
    .out_ce    (out_ce),
    .out_ue    (out_ue),
`ifdef SEC_STATS_EN
    .clr_cnt   (clr_cnt),
    .cnt_ce    (cnt_ce),
    .cnt_ue    (cnt_ue),
`endif
    .out_rem   (out_rem)
  );

  typedef struct {
    logic [13:0] din;
    logic [13:0] dout;
    logic [4:0]  loc;
    logic        ce;
    logic        ue;
    logic [9:0]  rem;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer one codeword in IDLE; returns after the accept edge.
  task automatic apply(input logic [13:0] d);
    @(negedge clk);
    check($sformatf("in_ready before %0d", d), 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid; bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic check_result(input vec_t v);
    check($sformatf("out_valid %0d", v.din), 32'(out_valid), 32'd1);
    check($sformatf("out_data %0d", v.din), 32'(out_data), 32'(v.dout));
    check($sformatf("out_loc %0d", v.din), 32'(out_loc), 32'(v.loc));
    check($sformatf("out_ce %0d", v.din), 32'(out_ce), 32'(v.ce));
    check($sformatf("out_ue %0d", v.din), 32'(out_ue), 32'(v.ue));
    check($sformatf("out_rem %0d", v.din), 32'(out_rem), 32'(v.rem));
    check($sformatf("in_ready busy %0d", v.din), 32'(in_ready), 32'd0);
  endtask

  // One-cycle out_ready pulse; controller must be idle on the next cycle.
  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("out_valid after ack", 32'(out_valid), 32'd0);
    check("in_ready after ack", 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    apply(v.din);
    wait_out(lat);
    check($sformatf("latency %0d", v.din), 32'(lat), 32'(v.lat));
    check_result(v);
    handshake();
  endtask

  initial begin
    int lat;
    // {in, expected data, loc (5-bit two's complement), ce, ue, rem, latency}
    vecs[0] = '{14'd1965,  14'd1965,  5'd0,  1'b0, 1'b0, 10'd0,   15};
    vecs[1] = '{14'd1973,  14'd1965,  5'd4,  1'b1, 1'b0, 10'd8,   19};
    vecs[2] = '{14'd1709,  14'd1965,  5'd23, 1'b1, 1'b0, 10'd399, 24};
    vecs[3] = '{14'd2989,  14'd1965,  5'd11, 1'b1, 1'b0, 10'd369, 26};
    vecs[4] = '{14'd1968,  14'd1968,  5'd0,  1'b0, 1'b1, 10'd3,   29};
    vecs[5] = '{14'd1966,  14'd1965,  5'd1,  1'b1, 1'b0, 10'd1,   16};
    vecs[6] = '{14'd1964,  14'd1965,  5'd31, 1'b1, 1'b0, 10'd654, 16};
    vecs[7] = '{14'd10157, 14'd1965,  5'd14, 1'b1, 1'b0, 10'd332, 29};
    vecs[8] = '{14'd16383, 14'd16375, 5'd4,  1'b1, 1'b0, 10'd8,   19};
    vecs[9] = '{14'd0,     14'd0,     5'd0,  1'b0, 1'b0, 10'd0,   15};

    // Reset state.
    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_rem", 32'(out_rem), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: back-to-back codewords.
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Output stall: held results stay stable, new input ignored.
    apply(14'd1973);
    wait_out(lat);
    check("stall latency", 32'(lat), 32'd19);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 14'd1709;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 check_result(vecs[1]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake();
    check("held out_data after ack", 32'(out_data), 32'd1965);
    check("held out_loc after ack", 32'(out_loc), 32'd4);
    // Ignored 1709 must not have been captured: next decode is the fresh one.
    run_vec(vecs[3]);

    // Reset during SEARCH aborts the codeword and clears outputs.
    apply(14'd1968);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data", 32'(out_data), 32'd0);
    check("abort out_loc", 32'(out_loc), 32'd0);
    check("abort out_ce", 32'(out_ce), 32'd0);
    check("abort out_ue", 32'(out_ue), 32'd0);
    check("abort out_rem", 32'(out_rem), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("no output after abort", 32'(out_valid), 32'd0);
    run_vec(vecs[2]);

`ifdef SEC_STATS_EN
    // Counters: cleared by reset, then 3 corrected + 1 uncorrectable.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("cnt_ce reset", 32'(cnt_ce), 32'd0);
    check("cnt_ue reset", 32'(cnt_ue), 32'd0);
    run_vec(vecs[1]);
    run_vec(vecs[0]);
    run_vec(vecs[2]);
    run_vec(vecs[4]);
    run_vec(vecs[3]);
    check("cnt_ce", 32'(cnt_ce), 32'd3);
    check("cnt_ue", 32'(cnt_ue), 32'd1);
    @(negedge clk);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    check("cnt_ce clr", 32'(cnt_ce), 32'd0);
    check("cnt_ue clr", 32'(cnt_ue), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
